sram_emulator: RTL and testbench
================================

SRAM_EMULATOR -- requirements
Module: sram_emulator

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_BITS, default 17, address width; array depth SHALL be 2**ADDR_BITS words.
REQ-003 Parameter ACCESS_CYCLES, default 5, clocks from request capture to completion; SHALL be >= 1, and values below 1 SHALL be rejected at elaboration.
REQ-004 Port clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port ce_n  input  1  chip enable, active-low.
REQ-007 Port oe_n  input  1  output enable (read request), active-low.
REQ-008 Port we_n  input  1  write enable, active-low.
REQ-009 Port be_n  input  WIDTH/8  byte-lane enables, active-low, bit i gates data byte i.
REQ-010 Port address  input  ADDR_BITS  word address.
REQ-011 Port wdata  input  WIDTH  write data.
REQ-012 Port rdata  output  WIDTH  registered read data.
REQ-013 Port rdata_valid  output  1  high while rdata holds the result of the most recent completed read.
REQ-014 Port busy  output  1  high while an access is in progress (state ACCESS).
REQ-015 Port done  output  1  one-cycle pulse on completion of a read or write.
REQ-016 Port aborted  output  1  one-cycle pulse when an access is cancelled.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-018 In IDLE, with ce_n=0 and (we_n=0 or oe_n=0) at an edge: capture address, wdata, be_n and operation, load counter=1, go to ACCESS.
REQ-019 With we_n=0 and oe_n=0 together, the operation SHALL be a write (WE dominates).
REQ-020 The counter SHALL be $clog2(ACCESS_CYCLES+1) bits and SHALL increment once per ACCESS cycle.
REQ-021 When a request is captured at edge k, memory update or rdata load and done=1 SHALL occur at edge k+ACCESS_CYCLES, and the FSM SHALL then enter DONE.
REQ-022 A read SHALL set rdata to mem[captured address] and set rdata_valid=1.
REQ-023 Any new capture SHALL clear rdata_valid, and rdata SHALL hold its previous value until it is overwritten.
REQ-024 Input changes during ACCESS SHALL be ignored; only the captured values SHALL be used.
REQ-025 ce_n=1 sampled during ACCESS SHALL abort the access: no memory change, rdata unchanged, aborted=1 for one cycle, return to IDLE.
REQ-026 DONE SHALL return to IDLE only when ce_n=1 or (we_n=1 and oe_n=1), giving one access per strobe assertion.
REQ-027 Address wrap-around SHALL NOT occur; each address SHALL map to exactly one word.
REQ-028 With ACCESS_CYCLES=1, done SHALL be asserted on the edge following capture.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, counter=0, rdata=0, rdata_valid=0, busy=0, done=0 and aborted=0.
REQ-030 Reset SHALL NOT clear array contents, and an access in flight at reset SHALL perform no write.

Configuration
REQ-031 Macro SRAM_EMU_BYTE_LANES_EN defined: a write SHALL update only the bytes whose captured be_n bit is 0, and a write with all be_n bits 1 SHALL still complete (done pulse) with no memory change.
REQ-032 Macro SRAM_EMU_BYTE_LANES_EN undefined: be_n SHALL be ignored and every write SHALL update the full word.
REQ-033 Reads SHALL always return the full word regardless of the macro.

Verification (WIDTH=16, ADDR_BITS=10, ACCESS_CYCLES=5)
REQ-034 Write 0xBEEF to address 0x3A5, then read it -> done 5 edges after each capture, rdata=0xBEEF, rdata_valid=1.
REQ-035 With the macro defined, write 0x1234 to address 7, then write 0xAB00 with be_n=2'b01 -> read of address 7 returns 0xAB34; with the macro undefined, the same read returns 0xAB00.
REQ-036 Raise ce_n on the 3rd ACCESS cycle of a write of 0x5555 to address 9 -> aborted pulse, no done pulse, address 9 keeps its old value.
REQ-037 Assert rst during the 4th ACCESS cycle of a read -> all outputs 0 in the same cycle, FSM in IDLE, memory unchanged.
REQ-038 Hold we_n=0 and oe_n=0 for 20 cycles with wdata=0x0F0F -> exactly one done pulse, a write occurs, and no re-access until the strobes are released.

Source files
------------

// File: rtl/sram_emulator.sv
// rtl/sram_emulator.sv - fixed-latency SRAM model with IDLE/ACCESS/DONE strobe handshake.
// Optional byte-lane write masking is enabled by defining SRAM_EMU_BYTE_LANES_EN.
module sram_emulator #(
    parameter int WIDTH         = 16,
    parameter int ADDR_BITS     = 17,
    parameter int ACCESS_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce_n,
    input  logic                 oe_n,
    input  logic                 we_n,
    input  logic [WIDTH/8-1:0]   be_n,
    input  logic [ADDR_BITS-1:0] address,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rdata_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    localparam int LANES = WIDTH / 8;
    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam int DEPTH = 2 ** ADDR_BITS;

    generate
        if (ACCESS_CYCLES < 1) begin : g_bad_access_cycles
            $error("sram_emulator: ACCESS_CYCLES must be >= 1");
        end
        if ((WIDTH % 8) != 0) begin : g_bad_width
            $error("sram_emulator: WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [WIDTH-1:0]       r_wdata;
    logic [LANES-1:0]       r_be_n;
    logic                   r_is_write;
    logic [WIDTH-1:0]       r_rdata;
    logic                   r_rdata_valid;
    logic                   r_done;
    logic                   r_aborted;
    logic [WIDTH-1:0]       r_mem [DEPTH];

    logic                   w_capture;
    logic                   w_complete;
    logic                   w_abort;
    logic                   w_mem_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!ce_n && (!we_n || !oe_n)) begin
                    w_capture  = 1'b1;
                    w_cnt_next = CNT_W'(1);
                    w_next     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Chip deselect wins over a completion landing on the same edge.
                if (ce_n) begin
                    w_abort    = 1'b1;
                    w_cnt_next = '0;
                    w_next     = S_IDLE;
                end else if (r_cnt == CNT_W'(ACCESS_CYCLES)) begin
                    w_complete = 1'b1;
                    w_cnt_next = '0;
                    w_next     = S_DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (ce_n || (we_n && oe_n)) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be_n     <= '1;
            r_is_write <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_capture) begin
                r_addr     <= address;
                r_wdata    <= wdata;
                r_be_n     <= be_n;
                r_is_write <= !we_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_done    <= w_complete;
            r_aborted <= w_abort;
            if (w_capture) begin
                r_rdata_valid <= 1'b0;
            end else if (w_complete && !r_is_write) begin
                r_rdata       <= r_mem[r_addr];
                r_rdata_valid <= 1'b1;
            end
        end
    end

    // Array has no reset; the rst term keeps an in-flight write from landing.
    assign w_mem_we = w_complete && r_is_write && !rst;

`ifdef SRAM_EMU_BYTE_LANES_EN
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (!r_be_n[i]) begin
                    r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end
`else
    logic w_unused_be;
    assign w_unused_be = ^r_be_n;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end
`endif

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign busy        = (r_state == S_ACCESS);
    assign done        = r_done;
    assign aborted     = r_aborted;

endmodule

// File: tb/tb_sram_emulator.sv
// tb/tb_sram_emulator.sv - directed self-checking bench for sram_emulator.
module tb_sram_emulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_n = 1'b1;
    logic        oe_n = 1'b1;
    logic        we_n = 1'b1;
    logic [1:0]  be_n = 2'b00;
    logic [9:0]  address = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        rdata_valid, busy, done, aborted;

    logic [15:0] rdata1;
    logic        rdata_valid1, busy1, done1, aborted1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_emulator #(.WIDTH(16), .ADDR_BITS(10), .ACCESS_CYCLES(5)) u_dut (
        .clk(clk), .rst(rst), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
        .be_n(be_n), .address(address), .wdata(wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
        .done(done), .aborted(aborted)
    );

    sram_emulator #(.WIDTH(16), .ADDR_BITS(4), .ACCESS_CYCLES(1)) u_dut_fast (
        .clk(clk), .rst(rst), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
        .be_n(be_n), .address(address[3:0]), .wdata(wdata),
        .rdata(rdata1), .rdata_valid(rdata_valid1), .busy(busy1),
        .done(done1), .aborted(aborted1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit wr, input logic [9:0] a, input logic [15:0] d,
                          input logic [1:0] be, output int lat);
        ce_n = 1'b0; we_n = !wr; oe_n = wr;
        address = a; wdata = d; be_n = be;
        tick();
        address = ~a; wdata = ~d; be_n = ~be;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        tick();
    endtask

    task automatic do_write(input string tag, input logic [9:0] a, input logic [15:0] d,
                            input logic [1:0] be);
        int lat;
        access(1'b1, a, d, be, lat);
        check({tag, "_wr_latency"}, lat, 5);
    endtask

    task automatic do_read(input string tag, input logic [9:0] a, input logic [15:0] exp);
        int lat;
        access(1'b0, a, 16'h0000, 2'b00, lat);
        check({tag, "_rd_latency"}, lat, 5);
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_rvalid"}, rdata_valid, 1);
    endtask

    task automatic reset_mid(input string tag, input bit wr, input logic [9:0] a,
                             input logic [15:0] d);
        ce_n = 1'b0; we_n = !wr; oe_n = wr; address = a; wdata = d; be_n = 2'b00;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check({tag, "_rst_rdata"}, rdata, 0);
        check({tag, "_rst_outs"}, {rdata_valid, busy, done, aborted}, 0);
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        tick();
        #3 rst = 1'b0;
        tick();
        check({tag, "_post_rst_busy"}, busy, 0);
    endtask

    initial begin
        int nd;
        int nb;
        #2;
        check("reset_rdata", rdata, 0);
        check("reset_flags", {rdata_valid, busy, done, aborted}, 0);
        tick();
        tick();
        #3 rst = 1'b0;
        tick();

        do_write("beef", 10'h3A5, 16'hBEEF, 2'b00);
        do_read("beef", 10'h3A5, 16'hBEEF);

        do_write("lane_a", 10'd7, 16'h1234, 2'b00);
        do_write("lane_b", 10'd7, 16'hAB00, 2'b01);
`ifdef SRAM_EMU_BYTE_LANES_EN
        do_read("lane", 10'd7, 16'hAB34);
`else
        do_read("lane", 10'd7, 16'hAB00);
`endif
        do_write("no_lane", 10'd7, 16'h9999, 2'b11);
`ifdef SRAM_EMU_BYTE_LANES_EN
        do_read("no_lane", 10'd7, 16'hAB34);
`else
        do_read("no_lane", 10'd7, 16'h9999);
`endif

        do_write("abort_pre", 10'd9, 16'h1111, 2'b00);
        do_read("abort_pre", 10'd9, 16'h1111);
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; address = 10'd9; wdata = 16'h5555;
        tick();
        check("abort_busy", busy, 1);
        check("abort_capture_clears_valid", rdata_valid, 0);
        tick();
        tick();
        ce_n = 1'b1;
        tick();
        check("abort_pulse", {aborted, done, busy}, 3'b100);
        check("abort_rdata_hold", rdata, 16'h1111);
        we_n = 1'b1;
        tick();
        check("abort_one_cycle", {aborted, done}, 2'b00);
        do_read("abort_post", 10'd9, 16'h1111);

        reset_mid("rst_read", 1'b0, 10'h3A5, 16'h0000);
        do_read("rst_read", 10'h3A5, 16'hBEEF);
        reset_mid("rst_write", 1'b1, 10'h3A5, 16'h0000);
        do_read("rst_write", 10'h3A5, 16'hBEEF);

        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
        address = 10'h010; wdata = 16'h0F0F; be_n = 2'b00;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) nd++;
            if (busy) nb++;
        end
        check("hold_done_count", nd, 1);
        check("hold_busy_cycles", nb, 5);
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        tick();
        do_read("hold", 10'h010, 16'h0F0F);

        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; address = 10'd3; wdata = 16'h00C3;
        tick();
        check("fast_wr_capture", {busy1, done1}, 2'b10);
        tick();
        check("fast_wr_done", {busy1, done1}, 2'b01);
        ce_n = 1'b1; we_n = 1'b1;
        tick();
        ce_n = 1'b0; oe_n = 1'b0;
        tick();
        check("fast_rd_capture", {busy1, done1, rdata_valid1}, 3'b100);
        tick();
        check("fast_rd_done", {done1, rdata_valid1}, 2'b11);
        check("fast_rd_rdata", rdata1, 16'h00C3);
        ce_n = 1'b1; oe_n = 1'b1;
        tick();
        tick();
        check("fast_no_abort_idle", aborted1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
